// File: rtl/ecc_secded_decoder.sv
`timescale 1ns/1ps
// ecc_secded_decoder: two-stage SECDED decoder for the memory read return path.
// Stage 1 registers the word with its syndrome and overall parity. Stage 2 holds
// the corrected word, its classification and its address. Status outputs record
// the correction pulse, the last corrected/uncorrectable addresses and a sticky flag.
// Handshake: a word moves on a rising clk edge where valid && ready; a producer
// holds valid and payload stable until ready; ready never depends on in_valid.
module ecc_secded_decoder #(
   parameter int ADDR_WIDTH = 12
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [15:0]           in_data,
   input  logic [5:0]            in_check,
   input  logic [ADDR_WIDTH-1:0] in_addr,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [15:0]           out_data,
   output logic                  out_corrected,
   output logic                  out_uncorrectable,
   output logic                  error_correction_event,
   output logic [ADDR_WIDTH-1:0] last_corr_addr,
   output logic [ADDR_WIDTH-1:0] last_uncorr_addr,
   output logic                  uncorr_sticky,
   input  logic                  sticky_clear
);

   // Hamming position (1..21) holding data bit i; powers of two hold check bits.
   function automatic logic [4:0] data_pos(input int i);
      case (i)
         0:       data_pos = 5'd3;
         1:       data_pos = 5'd5;
         2:       data_pos = 5'd6;
         3:       data_pos = 5'd7;
         4:       data_pos = 5'd9;
         5:       data_pos = 5'd10;
         6:       data_pos = 5'd11;
         7:       data_pos = 5'd12;
         8:       data_pos = 5'd13;
         9:       data_pos = 5'd14;
         10:      data_pos = 5'd15;
         11:      data_pos = 5'd17;
         12:      data_pos = 5'd18;
         13:      data_pos = 5'd19;
         14:      data_pos = 5'd20;
         15:      data_pos = 5'd21;
         default: data_pos = 5'd0;
      endcase
   endfunction

   // stage 1 registers
   logic                  s1_valid_q, s1_valid_d;
   logic [15:0]           s1_data_q, s1_data_d;
   logic [4:0]            s1_syn_q, s1_syn_d;
   logic                  s1_pe_q, s1_pe_d;
   logic [ADDR_WIDTH-1:0] s1_addr_q, s1_addr_d;

   // stage 2 registers (drive out_*)
   logic                  s2_valid_q, s2_valid_d;
   logic [15:0]           s2_data_q, s2_data_d;
   logic                  s2_corr_q, s2_corr_d;
   logic                  s2_uncorr_q, s2_uncorr_d;
   logic [ADDR_WIDTH-1:0] s2_addr_q, s2_addr_d;

   // status registers
   logic                  evt_q, evt_d;
   logic [ADDR_WIDTH-1:0] last_corr_q, last_corr_d;
   logic [ADDR_WIDTH-1:0] last_uncorr_q, last_uncorr_d;
   logic                  sticky_q, sticky_d;

   logic                  s1_advance;
   logic                  in_hs;
   logic                  out_hs;
   logic [21:0]           cw_in;
   logic [4:0]            syn_in;
   logic                  pe_in;
   logic [15:0]           fix_data;
   logic                  fix_corr;
   logic                  fix_uncorr;

   assign s1_advance = !s2_valid_q || out_ready;
   assign in_ready   = !s1_valid_q || s1_advance;
   assign in_hs      = in_valid && in_ready;
   assign out_hs     = s2_valid_q && out_ready;

   // Syndrome is the XOR of the positions of all set codeword bits; pe is total parity.
   always_comb begin
      cw_in     = '0;
      cw_in[1]  = in_check[0];
      cw_in[2]  = in_check[1];
      cw_in[4]  = in_check[2];
      cw_in[8]  = in_check[3];
      cw_in[16] = in_check[4];
      for (int i = 0; i < 16; i++) begin
         cw_in[data_pos(i)] = in_data[i];
      end
      syn_in = '0;
      for (int p = 1; p < 22; p++) begin
         if (cw_in[p]) syn_in = syn_in ^ 5'(p);
      end
      pe_in = (^cw_in) ^ in_check[5];
   end

   // Classify the stage-1 word and flip the data bit the syndrome points at.
   always_comb begin
      fix_corr   = s1_pe_q && (s1_syn_q <= 5'd21);
      fix_uncorr = (!s1_pe_q && (s1_syn_q != 5'd0)) || (s1_pe_q && (s1_syn_q > 5'd21));
      fix_data   = s1_data_q;
      for (int i = 0; i < 16; i++) begin
         if (fix_corr && (s1_syn_q == data_pos(i))) fix_data[i] = ~s1_data_q[i];
      end
   end

   // Stage 1 loads whenever it can accept a word.
   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_data_d  = s1_data_q;
      s1_syn_d   = s1_syn_q;
      s1_pe_d    = s1_pe_q;
      s1_addr_d  = s1_addr_q;
      if (in_ready) begin
         s1_valid_d = in_valid;
         if (in_valid) begin
            s1_data_d = in_data;
            s1_syn_d  = syn_in;
            s1_pe_d   = pe_in;
            s1_addr_d = in_addr;
         end
      end
   end

   // Stage 2 takes the classified word when empty or draining downstream.
   always_comb begin
      s2_valid_d  = s2_valid_q;
      s2_data_d   = s2_data_q;
      s2_corr_d   = s2_corr_q;
      s2_uncorr_d = s2_uncorr_q;
      s2_addr_d   = s2_addr_q;
      if (s1_advance) begin
         s2_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            s2_data_d   = fix_data;
            s2_corr_d   = fix_corr;
            s2_uncorr_d = fix_uncorr;
            s2_addr_d   = s1_addr_q;
         end
      end
   end

   // Status follows output handshakes only; a set of the sticky beats a clear.
   always_comb begin
      evt_d         = out_hs && s2_corr_q;
      last_corr_d   = (out_hs && s2_corr_q) ? s2_addr_q : last_corr_q;
      last_uncorr_d = (out_hs && s2_uncorr_q) ? s2_addr_q : last_uncorr_q;
      sticky_d      = sticky_q;
      if (sticky_clear) sticky_d = 1'b0;
      if (out_hs && s2_uncorr_q) sticky_d = 1'b1;
   end

   // All state, cleared asynchronously.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_valid_q    <= 1'b0;
         s1_data_q     <= '0;
         s1_syn_q      <= '0;
         s1_pe_q       <= 1'b0;
         s1_addr_q     <= '0;
         s2_valid_q    <= 1'b0;
         s2_data_q     <= '0;
         s2_corr_q     <= 1'b0;
         s2_uncorr_q   <= 1'b0;
         s2_addr_q     <= '0;
         evt_q         <= 1'b0;
         last_corr_q   <= '0;
         last_uncorr_q <= '0;
         sticky_q      <= 1'b0;
      end else begin
         s1_valid_q    <= s1_valid_d;
         s1_data_q     <= s1_data_d;
         s1_syn_q      <= s1_syn_d;
         s1_pe_q       <= s1_pe_d;
         s1_addr_q     <= s1_addr_d;
         s2_valid_q    <= s2_valid_d;
         s2_data_q     <= s2_data_d;
         s2_corr_q     <= s2_corr_d;
         s2_uncorr_q   <= s2_uncorr_d;
         s2_addr_q     <= s2_addr_d;
         evt_q         <= evt_d;
         last_corr_q   <= last_corr_d;
         last_uncorr_q <= last_uncorr_d;
         sticky_q      <= sticky_d;
      end
   end

   assign out_valid              = s2_valid_q;
   assign out_data               = s2_data_q;
   assign out_corrected          = s2_corr_q;
   assign out_uncorrectable      = s2_uncorr_q;
   assign error_correction_event = evt_q;
   assign last_corr_addr         = last_corr_q;
   assign last_uncorr_addr       = last_uncorr_q;
   assign uncorr_sticky          = sticky_q;

endmodule

// File: tb/tb_ecc_secded_decoder.sv
`timescale 1ns/1ps
// Directed bench for ecc_secded_decoder.
module tb_ecc_secded_decoder;

   logic        clk;
   logic        reset_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_data;
   logic [5:0]  in_check;
   logic [11:0] in_addr;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;
   logic        out_corrected;
   logic        out_uncorrectable;
   logic        error_correction_event;
   logic [11:0] last_corr_addr;
   logic [11:0] last_uncorr_addr;
   logic        uncorr_sticky;
   logic        sticky_clear;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int pulse_cnt = 0;
   int pulse_bad = 0;
   logic prev_corr_hs = 1'b0;

   logic [15:0] got_data[$];
   logic        got_corr[$];
   logic        got_unc[$];
   int          got_cyc[$];
   int          in_cyc_q[$];

   ecc_secded_decoder #(.ADDR_WIDTH(12)) dut (
      .clk(clk), .reset_n(reset_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_check(in_check), .in_addr(in_addr),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_corrected(out_corrected), .out_uncorrectable(out_uncorrectable),
      .error_correction_event(error_correction_event),
      .last_corr_addr(last_corr_addr), .last_uncorr_addr(last_uncorr_addr),
      .uncorr_sticky(uncorr_sticky), .sticky_clear(sticky_clear)
   );

   // clock / cycle counter
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // output monitor: records delivered words and checks pulse placement
   always @(negedge clk) begin
      if (!reset_n) begin
         prev_corr_hs = 1'b0;
      end else begin
         if (error_correction_event !== prev_corr_hs) pulse_bad++;
         if (error_correction_event) pulse_cnt++;
         prev_corr_hs = out_valid && out_ready && out_corrected;
         if (out_valid && out_ready) begin
            got_data.push_back(out_data);
            got_corr.push_back(out_corrected);
            got_unc.push_back(out_uncorrectable);
            got_cyc.push_back(cyc);
         end
      end
   end

   // reference encoder: check bits for a clean word
   function automatic logic [5:0] enc(input logic [15:0] d);
      logic [21:0] cw;
      logic [5:0]  c;
      int j;
      cw = '0;
      j = 0;
      for (int pos = 1; pos < 22; pos++) begin
         if (pos != 1 && pos != 2 && pos != 4 && pos != 8 && pos != 16) begin
            cw[pos] = d[j];
            j++;
         end
      end
      c = '0;
      for (int k = 0; k < 5; k++)
         for (int pos = 1; pos < 22; pos++)
            if (((pos >> k) & 1) == 1) c[k] = c[k] ^ cw[pos];
      c[5] = (^d) ^ (^c[4:0]);
      return c;
   endfunction

   task automatic clear_obs();
      got_data.delete();
      got_corr.delete();
      got_unc.delete();
      got_cyc.delete();
      in_cyc_q.delete();
      pulse_cnt = 0;
      pulse_bad = 0;
   endtask

   // driver: called just after a rising edge, returns just after the accepting edge
   task automatic send(input logic [15:0] d, input logic [5:0] c, input logic [11:0] a);
      int k;
      in_valid = 1'b1;
      in_data  = d;
      in_check = c;
      in_addr  = a;
      k = 0;
      while (!in_ready && k < 50) begin
         @(posedge clk); #1;
         k++;
      end
      tests++;
      if (k >= 50) begin
         fails++;
         $display("FAIL send_timeout: in_ready=%0b required 1 within 50 cycles", in_ready);
      end
      @(posedge clk); #1;
      in_cyc_q.push_back(cyc);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      repeat (5) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      in_valid = 1'b0; in_data = '0; in_check = '0; in_addr = '0;
      out_ready = 1'b0; sticky_clear = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_out_valid: got %0b need 0", out_valid); end
      tests++; if (error_correction_event !== 1'b0) begin fails++; $display("FAIL rst_event: got %0b need 0", error_correction_event); end
      tests++; if ({out_corrected, out_uncorrectable, uncorr_sticky} !== 3'b000) begin fails++; $display("FAIL rst_flags: got %b need 000", {out_corrected, out_uncorrectable, uncorr_sticky}); end
      tests++; if ({last_corr_addr, last_uncorr_addr} !== 24'h0) begin fails++; $display("FAIL rst_addrs: got %h need 000000", {last_corr_addr, last_uncorr_addr}); end
      reset_n = 1'b1;
      @(posedge clk); #1;
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rst_in_ready: got %0b need 1", in_ready); end
   endtask

   task automatic test_clean_stream();
      logic [15:0] wd [8];
      logic [5:0]  wc [8];
      wd[0] = 16'h0000; wc[0] = 6'h00;
      wd[1] = 16'hFFFF; wc[1] = 6'h1E;
      wd[2] = 16'hA5C3; wc[2] = 6'h05;
      wd[3] = 16'h1234; wc[3] = enc(16'h1234);
      wd[4] = 16'h8001; wc[4] = enc(16'h8001);
      wd[5] = 16'h7FFE; wc[5] = enc(16'h7FFE);
      wd[6] = 16'h5A5A; wc[6] = enc(16'h5A5A);
      wd[7] = 16'h0F0F; wc[7] = enc(16'h0F0F);
      out_ready = 1'b1;
      clear_obs();
      for (int i = 0; i < 8; i++) send(wd[i], wc[i], 12'h100 + 12'(i));
      drain();
      tests++; if (got_data.size() != 8) begin fails++; $display("FAIL clean_count: got %0d need 8", got_data.size()); end
      if (got_data.size() == 8 && in_cyc_q.size() == 8) begin
         for (int i = 0; i < 8; i++) begin
            tests++; if (got_data[i] !== wd[i]) begin fails++; $display("FAIL clean_data[%0d]: got %h need %h", i, got_data[i], wd[i]); end
            tests++; if ({got_corr[i], got_unc[i]} !== 2'b00) begin fails++; $display("FAIL clean_flags[%0d]: got %b need 00", i, {got_corr[i], got_unc[i]}); end
            tests++; if (got_cyc[i] - in_cyc_q[i] != 1) begin fails++; $display("FAIL clean_latency[%0d]: got %0d need 1", i, got_cyc[i] - in_cyc_q[i]); end
         end
         tests++; if (got_cyc[7] - got_cyc[0] != 7) begin fails++; $display("FAIL clean_throughput: got span %0d need 7", got_cyc[7] - got_cyc[0]); end
      end
      tests++; if (pulse_cnt != 0) begin fails++; $display("FAIL clean_pulses: got %0d need 0", pulse_cnt); end
   endtask

   task automatic test_single_data();
      logic [15:0] flip [2];
      logic [11:0] addr [2];
      flip[0] = 16'h0080; addr[0] = 12'h3A7;  // position 12
      flip[1] = 16'h8000; addr[1] = 12'h3A8;  // position 21, last valid syndrome
      out_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         clear_obs();
         send(16'hA5C3 ^ flip[i], 6'h05, addr[i]);
         drain();
         tests++; if (got_data.size() != 1) begin fails++; $display("FAIL sdata_count[%0d]: got %0d need 1", i, got_data.size()); end
         if (got_data.size() == 1) begin
            tests++; if (got_data[0] !== 16'hA5C3) begin fails++; $display("FAIL sdata_data[%0d]: got %h need a5c3", i, got_data[0]); end
            tests++; if ({got_corr[0], got_unc[0]} !== 2'b10) begin fails++; $display("FAIL sdata_flags[%0d]: got %b need 10", i, {got_corr[0], got_unc[0]}); end
         end
         tests++; if (pulse_cnt != 1 || pulse_bad != 0) begin fails++; $display("FAIL sdata_pulse[%0d]: got %0d (bad %0d) need 1 (bad 0)", i, pulse_cnt, pulse_bad); end
         tests++; if (last_corr_addr !== addr[i]) begin fails++; $display("FAIL sdata_addr[%0d]: got %h need %h", i, last_corr_addr, addr[i]); end
      end
   endtask

   task automatic test_single_check();
      logic [5:0]  flip [2];
      logic [11:0] addr [2];
      flip[0] = 6'h04; addr[0] = 12'h041;
      flip[1] = 6'h20; addr[1] = 12'h042;
      out_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         clear_obs();
         send(16'hA5C3, 6'h05 ^ flip[i], addr[i]);
         drain();
         tests++; if (got_data.size() != 1) begin fails++; $display("FAIL schk_count[%0d]: got %0d need 1", i, got_data.size()); end
         if (got_data.size() == 1) begin
            tests++; if (got_data[0] !== 16'hA5C3) begin fails++; $display("FAIL schk_data[%0d]: got %h need a5c3", i, got_data[0]); end
            tests++; if ({got_corr[0], got_unc[0]} !== 2'b10) begin fails++; $display("FAIL schk_flags[%0d]: got %b need 10", i, {got_corr[0], got_unc[0]}); end
         end
         tests++; if (pulse_cnt != 1 || pulse_bad != 0) begin fails++; $display("FAIL schk_pulse[%0d]: got %0d (bad %0d) need 1 (bad 0)", i, pulse_cnt, pulse_bad); end
         tests++; if (last_corr_addr !== addr[i]) begin fails++; $display("FAIL schk_addr[%0d]: got %h need %h", i, last_corr_addr, addr[i]); end
      end
   endtask

   task automatic test_double();
      out_ready = 1'b1;
      clear_obs();
      send(16'hA7C2, 6'h05, 12'h5B1);  // data bits 0 and 9 flipped
      drain();
      tests++; if (got_data.size() != 1) begin fails++; $display("FAIL dbl_count: got %0d need 1", got_data.size()); end
      if (got_data.size() == 1) begin
         tests++; if (got_data[0] !== 16'hA7C2) begin fails++; $display("FAIL dbl_data: got %h need a7c2", got_data[0]); end
         tests++; if ({got_corr[0], got_unc[0]} !== 2'b01) begin fails++; $display("FAIL dbl_flags: got %b need 01", {got_corr[0], got_unc[0]}); end
      end
      tests++; if (pulse_cnt != 0) begin fails++; $display("FAIL dbl_pulse: got %0d need 0", pulse_cnt); end
      tests++; if (uncorr_sticky !== 1'b1) begin fails++; $display("FAIL dbl_sticky: got %0b need 1", uncorr_sticky); end
      tests++; if (last_uncorr_addr !== 12'h5B1) begin fails++; $display("FAIL dbl_addr: got %h need 5b1", last_uncorr_addr); end
      tests++; if (last_corr_addr !== 12'h042) begin fails++; $display("FAIL dbl_corr_addr_kept: got %h need 042", last_corr_addr); end
      sticky_clear = 1'b1;
      @(posedge clk); #1;
      sticky_clear = 1'b0;
      tests++; if (uncorr_sticky !== 1'b0) begin fails++; $display("FAIL dbl_sticky_clear: got %0b need 0", uncorr_sticky); end
      send(16'hA7C2, 6'h05, 12'h5B2);
      @(posedge clk); #1;
      tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL dbl_second_valid: got %0b need 1", out_valid); end
      sticky_clear = 1'b1;
      @(posedge clk); #1;
      sticky_clear = 1'b0;
      tests++; if (uncorr_sticky !== 1'b1) begin fails++; $display("FAIL dbl_set_wins: got %0b need 1", uncorr_sticky); end
      tests++; if (last_uncorr_addr !== 12'h5B2) begin fails++; $display("FAIL dbl_addr2: got %h need 5b2", last_uncorr_addr); end
   endtask

   task automatic test_triple();
      out_ready = 1'b1;
      clear_obs();
      send(16'hA5C3, 6'h05 ^ 6'h38, 12'h6C0);  // syndrome 24, parity odd
      drain();
      tests++; if (got_data.size() != 1) begin fails++; $display("FAIL big_syn_count: got %0d need 1", got_data.size()); end
      if (got_data.size() == 1) begin
         tests++; if (got_data[0] !== 16'hA5C3) begin fails++; $display("FAIL big_syn_data: got %h need a5c3", got_data[0]); end
         tests++; if ({got_corr[0], got_unc[0]} !== 2'b01) begin fails++; $display("FAIL big_syn_flags: got %b need 01", {got_corr[0], got_unc[0]}); end
      end
      tests++; if (pulse_cnt != 0) begin fails++; $display("FAIL big_syn_pulse: got %0d need 0", pulse_cnt); end
      tests++; if (last_uncorr_addr !== 12'h6C0) begin fails++; $display("FAIL big_syn_addr: got %h need 6c0", last_uncorr_addr); end
   endtask

   task automatic test_back_to_back();
      logic [15:0] exp_d [3];
      exp_d[0] = 16'h1234; exp_d[1] = 16'hBEEF; exp_d[2] = 16'h0F0F;
      out_ready = 1'b0;
      clear_obs();
      send(16'h1234 ^ 16'h0008, enc(16'h1234), 12'h201);
      send(16'hBEEF ^ 16'h8000, enc(16'hBEEF), 12'h202);
      in_valid = 1'b1;
      in_data  = 16'h0F0F;
      in_check = enc(16'h0F0F) ^ 6'h01;
      in_addr  = 12'h203;
      tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready_full: got %0b need 0", in_ready); end
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         tests++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin fails++; $display("FAIL bp_stall[%0d]: in_ready %0b out_valid %0b need 0 1", i, in_ready, out_valid); end
         tests++; if (out_data !== 16'h1234 || out_corrected !== 1'b1) begin fails++; $display("FAIL bp_hold[%0d]: got %h/%0b need 1234/1", i, out_data, out_corrected); end
      end
      tests++; if (pulse_cnt != 0) begin fails++; $display("FAIL bp_stall_pulse: got %0d need 0", pulse_cnt); end
      out_ready = 1'b1;
      #1;
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_release_ready: got %0b need 1", in_ready); end
      @(posedge clk); #1;
      in_valid = 1'b0;
      drain();
      tests++; if (got_data.size() != 3) begin fails++; $display("FAIL bp_count: got %0d need 3", got_data.size()); end
      if (got_data.size() == 3) begin
         for (int i = 0; i < 3; i++) begin
            tests++; if (got_data[i] !== exp_d[i] || got_corr[i] !== 1'b1) begin fails++; $display("FAIL bp_word[%0d]: got %h/%0b need %h/1", i, got_data[i], got_corr[i], exp_d[i]); end
         end
      end
      tests++; if (pulse_cnt != 3 || pulse_bad != 0) begin fails++; $display("FAIL bp_pulses: got %0d (bad %0d) need 3 (bad 0)", pulse_cnt, pulse_bad); end
      tests++; if (last_corr_addr !== 12'h203) begin fails++; $display("FAIL bp_addr: got %h need 203", last_corr_addr); end
   endtask

   task automatic test_reset_mid();
      logic [5:0] c;
      out_ready = 1'b0;
      clear_obs();
      send(16'hA5C3 ^ 16'h0080, 6'h05, 12'h7F1);
      send(16'hA7C2, 6'h05, 12'h7F2);
      tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL rmid_loaded: got %0b need 1", out_valid); end
      reset_n = 1'b0;
      #1;
      tests++; if (out_valid !== 1'b0 || error_correction_event !== 1'b0) begin fails++; $display("FAIL rmid_valid: got %0b/%0b need 0/0", out_valid, error_correction_event); end
      tests++; if ({out_corrected, out_uncorrectable, uncorr_sticky} !== 3'b000) begin fails++; $display("FAIL rmid_flags: got %b need 000", {out_corrected, out_uncorrectable, uncorr_sticky}); end
      tests++; if ({last_corr_addr, last_uncorr_addr} !== 24'h0) begin fails++; $display("FAIL rmid_addrs: got %h need 000000", {last_corr_addr, last_uncorr_addr}); end
      @(posedge clk); #1;
      reset_n = 1'b1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rmid_in_ready: got %0b need 1", in_ready); end
      clear_obs();
      c = enc(16'h1234);
      send(16'h1234, c, 12'h0AA);
      drain();
      tests++; if (got_data.size() != 1) begin fails++; $display("FAIL rmid_count: got %0d need 1", got_data.size()); end
      if (got_data.size() == 1) begin
         tests++; if (got_data[0] !== 16'h1234 || {got_corr[0], got_unc[0]} !== 2'b00) begin fails++; $display("FAIL rmid_word: got %h/%b need 1234/00", got_data[0], {got_corr[0], got_unc[0]}); end
      end
      tests++; if (pulse_cnt != 0) begin fails++; $display("FAIL rmid_pulse: got %0d need 0", pulse_cnt); end
   endtask

   initial begin
      test_reset();
      test_clean_stream();
      test_single_data();
      test_single_check();
      test_double();
      test_triple();
      test_back_to_back();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
